// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// mult/multu finish after MUL_LAT cycles; div/divu after 32 restoring steps plus a sign-fix cycle.
module mul_div_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mul_control,
    input  logic        issue_valid,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        issue_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_sgn;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_onehot;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_signed;
    logic        w_complete;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Handshake: an issue is taken on a rising edge when issue_valid & issue_ready,
    // mul_control is exactly one-hot and flush is low; anything else is ignored.
    assign w_onehot   = (mul_control != 4'd0) && ((mul_control & (mul_control - 4'd1)) == 4'd0);
    assign w_accept   = issue_valid && (r_state == ST_IDLE) && w_onehot && !flush;
    assign w_is_mul   = mul_control[0] | mul_control[1];
    assign w_signed   = mul_control[0] | mul_control[2];
    assign w_complete = !flush && (((r_state == ST_MUL) && (r_cnt == 5'd0)) || (r_state == ST_FIX));

    assign w_abs_a = (w_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign w_abs_b = (w_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

    // Restoring step: the shifted remainder is always below twice the divisor, so the low 32 bits of
    // the subtraction are exact whenever the compare succeeds.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = w_shift >= {1'b0, r_b};
    assign w_sub   = w_shift[31:0] - r_b;

    assign w_ext_a = {{32{r_sgn & r_a[31]}}, r_a};
    assign w_ext_b = {{32{r_sgn & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_state == ST_FIX) begin
            if (r_b == 32'd0) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = r_neg_r ? (~r_rem + 32'd1) : r_rem;
                w_res_lo = r_neg_q ? (~r_quo + 32'd1) : r_quo;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_is_mul ? ST_MUL : ST_DIV;
            ST_MUL:  if (r_cnt == 5'd0) w_next = ST_IDLE;
            ST_DIV:  if (r_cnt == 5'd0) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush && (r_state != ST_IDLE)) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept) begin
                r_a     <= op_a;
                r_b     <= w_is_mul ? op_b : w_abs_b;
                r_sgn   <= w_signed;
                r_quo   <= w_abs_a;
                r_rem   <= 32'd0;
                r_neg_q <= w_signed & (op_a[31] ^ op_b[31]);
                r_neg_r <= w_signed & op_a[31];
                r_cnt   <= w_is_mul ? 5'(MUL_LAT - 1) : 5'd31;
            end else begin
                if (r_state == ST_DIV) begin
                    r_rem <= w_ge ? w_sub : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                end
                if (((r_state == ST_MUL) || (r_state == ST_DIV)) && (r_cnt != 5'd0))
                    r_cnt <= r_cnt - 5'd1;
            end
            // A move-to write on the completion edge takes priority for its own register.
            if (hi_wen)          r_hi <= wdata;
            else if (w_complete) r_hi <= w_res_hi;
            if (lo_wen)          r_lo <= wdata;
            else if (w_complete) r_lo <= w_res_lo;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign issue_ready = !busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign dbg_state   = r_state;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide responder that executes the 4-bit mul_control command produced by the instruction decoder for mult, multu, div and divu.
- Owns the architectural HI/LO registers and accepts mthi/mtlo writes.
- Sits beside the ALU in EX; mfhi/mflo read hi/lo directly.
- Stalls the pipeline through busy while an operation is in flight.

Parameters:
- MUL_LAT, 2: cycles from issue to HI/LO update for mult/multu; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous assert, active-high
- mul_control  in  4  one-hot command: bit0 mult, bit1 multu, bit2 div, bit3 divu; 0 means no op
- issue_valid  in  1  command and operands valid this cycle
- op_a  in  32  rs value (multiplicand or dividend)
- op_b  in  32  rt value (multiplier or divisor)
- hi_wen  in  1  mthi write strobe
- lo_wen  in  1  mtlo write strobe
- wdata  in  32  mthi/mtlo data
- flush  in  1  exception/eret cancel of the in-flight operation
- issue_ready  out  1  equals !busy
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE. Reset asserted mid-operation discards the operation immediately.
- Issue acceptance requires issue_valid & issue_ready & exactly one bit of mul_control set & !flush. Any other case leaves state unchanged; mul_control values with 2 or more bits set are ignored.
- States:
  - IDLE: accept issue -> MUL or DIV.
  - MUL: counter runs MUL_LAT-1..0; at 0 write HI/LO -> IDLE.
  - DIV: 32 restoring iterations, then one sign-fix cycle; write HI/LO -> IDLE.
- Timing:
  - busy rises on the edge that accepts the issue.
  - HI/LO update, busy falls and done pulses all on the same edge.
  - mult: done visible MUL_LAT cycles after the issue cycle.
  - div: done visible 33 cycles after the issue cycle.
  - A new issue is accepted in the done cycle (back-to-back).
- Operands are latched at issue; op_a/op_b may change afterwards.
- mult: {hi,lo} = signed 64-bit product. multu: unsigned 64-bit product.
- div/divu: lo = quotient, hi = remainder.
  - Signed: operate on magnitudes; quotient negated iff sign(a)^sign(b); remainder takes the sign of a.
- Divide by zero (both signed and unsigned): lo = 32'hFFFFFFFF, hi = op_a. Full latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo:
  - hi_wen/lo_wen write on the next edge regardless of state.
  - If a write coincides with the completion edge, the write wins for that register; the other register takes the result.
  - A write while busy that does not coincide with completion is overwritten by the later completion.
- flush:
  - While busy: next edge returns to IDLE, busy=0, done stays 0, HI/LO keep prior values.
  - In IDLE: flush blocks any issue that cycle.
  - hi_wen/lo_wen in the flush cycle are still honoured.
  - A flush arriving on the completion edge cancels it (no HI/LO update, no done).

Test Plan:
- Reset with rst high asynchronously mid-divide -> hi=0, lo=0, busy=0, done=0 immediately, without waiting for a clock edge.
- mult 0xFFFFFFFE x 3 (MUL_LAT=2) -> done 2 cycles after issue, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div -7 / 2 -> done at cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 5/0 -> lo=0xFFFFFFFF, hi=5 at cycle 33. A second issue held during busy is not accepted until the done cycle and then completes normally.
- Flush at cycle 10 of a div -> busy low next cycle, done never pulses, HI/LO unchanged. Flush and issue in the same IDLE cycle -> no operation starts.
- mthi 0x1234 on the exact completion edge of mult 2x3 -> hi=0x1234, lo=6. mtlo 0xAA at cycle 5 of a div -> lo=0xAA at cycle 6, then the quotient at completion.
